// File: rtl/pkg_npu.sv
// rtl/pkg_npu.sv - shared types and constants for the NPU activation sequencer
package pkg_npu;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } act_seq_state_e;

  typedef enum logic [1:0] {
    ActNone    = 2'd0,
    ActRelu    = 2'd1,
    ActSigmoid = 2'd2,
    ActTanh    = 2'd3
  } act_type_e;

  localparam logic [1:0] SkidDepth = 2'd2;

endpackage

// File: rtl/D_FF.sv
// rtl/D_FF.sv - resettable register cell used for FSM state and counters
module D_FF #(
  parameter int unsigned      Width    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_o <= ResetVal;
    else         q_o <= d_i;
  end

endmodule

// File: rtl/npu_skid_buf.sv
// rtl/npu_skid_buf.sv - 2-entry valid/ready buffer with occupancy output
// When empty, incoming data bypasses straight to the output.
module npu_skid_buf #(
  parameter int unsigned DWidth = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [DWidth-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DWidth-1:0] out_data_o,
  output logic [1:0]        occ_o
);

  logic [1:0]        occ_q, occ_d;
  logic [DWidth-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic              pop;

  always_comb begin
    out_valid_o = (occ_q != 2'd0) || in_valid_i;
    out_data_o  = (occ_q != 2'd0) ? ent0_q : in_data_i;
    pop         = out_valid_o && out_ready_i;
    occ_d       = occ_q;
    ent0_d      = ent0_q;
    ent1_d      = ent1_q;
    case (occ_q)
      2'd0: begin
        if (in_valid_i && !out_ready_i) begin
          ent0_d = in_data_i;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (pop) begin
          if (in_valid_i) ent0_d = in_data_i;
          else            occ_d  = 2'd0;
        end else if (in_valid_i) begin
          ent1_d = in_data_i;
          occ_d  = 2'd2;
        end
      end
      default: begin
        // Full: the caller never presents data here without a pop.
        if (pop) begin
          ent0_d = ent1_q;
          if (in_valid_i) ent1_d = in_data_i;
          else            occ_d  = 2'd1;
        end
      end
    endcase
    if (flush_i) occ_d = 2'd0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q  <= 2'd0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      occ_q  <= occ_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
    end
  end

  assign occ_o = occ_q;

endmodule

// File: rtl/npu_act_seq.sv
// rtl/npu_act_seq.sv - activation sequencer: input buffer -> activation unit -> output buffer
// Optional NPU_ACT_SEQ_PERF_EN adds busy-cycle and stall counters.
module npu_act_seq
  import pkg_npu::*;
#(
  parameter int unsigned DWidth = 32,
  parameter int unsigned AWidth = 8,
  parameter int unsigned TWidth = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [AWidth-1:0] len_i,
  input  logic [TWidth-1:0] type_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              imem_ren_o,
  output logic [AWidth-1:0] imem_addr_o,
  input  logic [DWidth-1:0] imem_rdata_i,
  output logic              act_valid_o,
  input  logic              act_ready_i,
  output logic [DWidth-1:0] act_data_o,
  output logic [TWidth-1:0] act_type_o,
  input  logic              res_valid_i,
  input  logic [DWidth-1:0] res_data_i,
  output logic              omem_wen_o,
  output logic [AWidth-1:0] omem_addr_o,
  output logic [DWidth-1:0] omem_wdata_o
`ifdef NPU_ACT_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cycles_o,
  output logic [31:0]       perf_stall_o
`endif
);

  act_seq_state_e    state_q, state_d;
  logic [1:0]        state_raw_q;
  logic [AWidth-1:0] len_q, len_d, rd_idx_q, rd_idx_d, wr_cnt_q, wr_cnt_d;
  logic [TWidth-1:0] type_q, type_d;
  logic              inflight_q, inflight_d;
  logic              busy, start_acc, ren, wen, flush;
  logic              skid_valid;
  logic [DWidth-1:0] skid_data;
  logic [1:0]        skid_occ;

  assign state_q = act_seq_state_e'(state_raw_q);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    type_d    = type_q;
    rd_idx_d  = rd_idx_q;
    wr_cnt_d  = wr_cnt_q;
    busy      = (state_q == StRun) || (state_q == StDrain);
    start_acc = (state_q == StIdle) && start_i;
    // Read only while buffered plus in-flight words leave room in the skid.
    ren       = (state_q == StRun) && !abort_i &&
                ((skid_occ + {1'b0, inflight_q}) < SkidDepth);
    wen       = busy && res_valid_i;
    flush     = busy && abort_i;
    if (ren) rd_idx_d = rd_idx_q + AWidth'(1);
    if (wen) wr_cnt_d = wr_cnt_q + AWidth'(1);
    inflight_d = ren;
    case (state_q)
      StIdle: begin
        if (start_acc) begin
          len_d    = len_i;
          type_d   = type_i;
          rd_idx_d = '0;
          wr_cnt_d = '0;
          state_d  = (len_i == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (abort_i)                 state_d = StIdle;
        else if (rd_idx_d == len_q)  state_d = StDrain;
      end
      StDrain: begin
        if (abort_i)                 state_d = StIdle;
        else if (wr_cnt_d == len_q)  state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  D_FF #(.Width(2))      u_state_ff    (.clk_i, .rst_ni, .d_i(state_d),    .q_o(state_raw_q));
  D_FF #(.Width(AWidth)) u_len_ff      (.clk_i, .rst_ni, .d_i(len_d),      .q_o(len_q));
  D_FF #(.Width(TWidth)) u_type_ff     (.clk_i, .rst_ni, .d_i(type_d),     .q_o(type_q));
  D_FF #(.Width(AWidth)) u_rd_idx_ff   (.clk_i, .rst_ni, .d_i(rd_idx_d),   .q_o(rd_idx_q));
  D_FF #(.Width(AWidth)) u_wr_cnt_ff   (.clk_i, .rst_ni, .d_i(wr_cnt_d),   .q_o(wr_cnt_q));
  D_FF #(.Width(1))      u_inflight_ff (.clk_i, .rst_ni, .d_i(inflight_d), .q_o(inflight_q));

  npu_skid_buf #(.DWidth(DWidth)) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush),
    .in_valid_i  (inflight_q),
    .in_data_i   (imem_rdata_i),
    .out_valid_o (skid_valid),
    .out_ready_i (busy && act_ready_i),
    .out_data_o  (skid_data),
    .occ_o       (skid_occ)
  );

  assign busy_o       = busy;
  assign done_o       = (state_q == StDone);
  assign imem_ren_o   = ren;
  assign imem_addr_o  = rd_idx_q;
  assign act_valid_o  = busy && skid_valid;
  assign act_data_o   = act_valid_o ? skid_data : '0;
  assign act_type_o   = type_q;
  assign omem_wen_o   = wen;
  assign omem_addr_o  = wr_cnt_q;
  assign omem_wdata_o = wen ? res_data_i : '0;

`ifdef NPU_ACT_SEQ_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stall_d  = perf_stall_q;
    if (start_acc) begin
      perf_cycles_d = '0;
      perf_stall_d  = '0;
    end else begin
      if (busy && !(&perf_cycles_q)) perf_cycles_d = perf_cycles_q + 32'd1;
      if (act_valid_o && !act_ready_i && !(&perf_stall_q)) perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  D_FF #(.Width(32)) u_perf_cycles_ff (.clk_i, .rst_ni, .d_i(perf_cycles_d), .q_o(perf_cycles_q));
  D_FF #(.Width(32)) u_perf_stall_ff  (.clk_i, .rst_ni, .d_i(perf_stall_d),  .q_o(perf_stall_q));

  assign perf_cycles_o = perf_cycles_q;
  assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_npu_act_seq.sv
// tb/tb_npu_act_seq.sv - self-checking bench for npu_act_seq with buffer/activation responders
`timescale 1ns/1ps
module tb_npu_act_seq;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0, abort_i = 1'b0;
  logic [AW-1:0] len_i = '0;
  logic [TW-1:0] type_i = '0;
  logic [DW-1:0] imem_rdata_i = '0, res_data_i = '0;
  logic          act_ready_i = 1'b1, res_valid_i = 1'b0;
  logic          busy_o, done_o, imem_ren_o, act_valid_o, omem_wen_o;
  logic [AW-1:0] imem_addr_o, omem_addr_o;
  logic [DW-1:0] act_data_o, omem_wdata_o;
  logic [TW-1:0] act_type_o;
`ifdef NPU_ACT_SEQ_PERF_EN
  logic [31:0]   perf_cycles_o, perf_stall_o;
`endif

  npu_act_seq #(.DWidth(DW), .AWidth(AW), .TWidth(TW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .len_i        (len_i),
    .type_i       (type_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .imem_ren_o   (imem_ren_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rdata_i (imem_rdata_i),
    .act_valid_o  (act_valid_o),
    .act_ready_i  (act_ready_i),
    .act_data_o   (act_data_o),
    .act_type_o   (act_type_o),
    .res_valid_i  (res_valid_i),
    .res_data_i   (res_data_i),
    .omem_wen_o   (omem_wen_o),
    .omem_addr_o  (omem_addr_o),
    .omem_wdata_o (omem_wdata_o)
`ifdef NPU_ACT_SEQ_PERF_EN
    ,
    .perf_cycles_o(perf_cycles_o),
    .perf_stall_o (perf_stall_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0, cyc = 0;
  logic [7:0] seed = 8'h00;
  int job_len = 0, exp_rd = 0, exp_xfer = 0, exp_wr = 0;
  int ren_cnt = 0, xfer_cnt = 0, done_cnt = 0;
  int start_cyc = 0, first_ren_cyc = -1, last_ren_cyc = -1, done_cyc = -1, last_busy_cyc = -1;
  bit busy_seen = 1'b0;
  logic [1:0] job_type = 2'd0;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {seed, 8'h3C, a, ~a};
  endfunction

  function automatic bit outputs_zero();
    return {busy_o, done_o, imem_ren_o, imem_addr_o, act_valid_o, act_data_o, act_type_o,
            omem_wen_o, omem_addr_o, omem_wdata_o} == '0;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Input buffer returns data one cycle after a read; activation unit echoes one cycle after a transfer.
  logic          mem_pend = 1'b0, res_pend = 1'b0;
  logic [AW-1:0] mem_pend_addr = '0;
  logic [DW-1:0] res_pend_data = '0;

  always @(negedge clk) begin
    mem_pend      = imem_ren_o;
    mem_pend_addr = imem_addr_o;
    res_pend      = act_valid_o && act_ready_i;
    res_pend_data = act_data_o;
  end

  always @(posedge clk) begin
    #1;
    imem_rdata_i = mem_pend ? mem_word(mem_pend_addr) : 32'hDEAD_BEEF;
    res_valid_i  = res_pend;
    res_data_i   = res_pend ? res_pend_data : 32'hBAD0_BAD0;
  end

  // Scoreboard: in-order reads, transfers and writes against the job the bench launched.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy_o) begin
        busy_seen     = 1'b1;
        last_busy_cyc = cyc;
        chk("act_type_hold", act_type_o, job_type);
        chk("outstanding_le2", (ren_cnt - xfer_cnt) <= 2, 1);
      end else begin
        chk("idle_quiet", {imem_ren_o, act_valid_o, omem_wen_o}, 0);
      end
      if (imem_ren_o) begin
        chk("rd_addr", imem_addr_o, exp_rd);
        chk("rd_in_range", exp_rd < job_len, 1);
        if (first_ren_cyc < 0) first_ren_cyc = cyc;
        last_ren_cyc = cyc;
        exp_rd++;
        ren_cnt++;
      end
      if (act_valid_o && act_ready_i) begin
        chk("act_data", act_data_o, mem_word(exp_xfer[7:0]));
        exp_xfer++;
        xfer_cnt++;
      end
      if (omem_wen_o) begin
        chk("wr_addr", omem_addr_o, exp_wr);
        chk("wr_data", omem_wdata_o, mem_word(exp_wr[7:0]));
        exp_wr++;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_not_busy", busy_o, 0);
        chk("done_all_written", exp_wr, job_len);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len, input int typ, input logic [7:0] sd);
    seed = sd; job_len = len; job_type = typ[1:0];
    exp_rd = 0; exp_xfer = 0; exp_wr = 0; ren_cnt = 0; xfer_cnt = 0; done_cnt = 0;
    first_ren_cyc = -1; last_ren_cyc = -1; done_cyc = -1; last_busy_cyc = -1; busy_seen = 1'b0;
    start_cyc = cyc;
    start_i = 1'b1; len_i = len[AW-1:0]; type_i = typ[TW-1:0];
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    chk({name, "_done_seen"}, done_cnt != 0, 1);
    repeat (2) step();
  endtask

  task automatic wait_xfers(input string name, input int target, input int budget);
    int n = 0;
    while (xfer_cnt < target && n < budget) begin
      step();
      n++;
    end
    chk({name, "_xfers_reached"}, xfer_cnt >= target, 1);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_zero", outputs_zero(), 1);
    chk("reset_busy", busy_o, 0);
`ifdef NPU_ACT_SEQ_PERF_EN
    chk("reset_perf", {perf_cycles_o, perf_stall_o}, 0);
`endif
    rst_n = 1'b1;
    step();

    // Basic run
    start_job(4, 1, 8'h11);
    wait_done("basic", 50);
    chk("basic_first_ren", first_ren_cyc - start_cyc, 1);
    chk("basic_ren_span", last_ren_cyc - first_ren_cyc, 3);
    chk("basic_ren_cnt", ren_cnt, 4);
    chk("basic_wr_cnt", exp_wr, 4);
    chk("basic_done_lat", done_cyc - start_cyc, 7);
    chk("basic_busy_fall", done_cyc - last_busy_cyc, 1);
    chk("basic_done_once", done_cnt, 1);

    // Backpressure
    start_job(8, 2, 8'h22);
    wait_xfers("bp", 1, 20);
    act_ready_i = 1'b0;
    repeat (5) step();
    act_ready_i = 1'b1;
    wait_done("bp", 100);
    chk("bp_ren_cnt", ren_cnt, 8);
    chk("bp_xfer_cnt", xfer_cnt, 8);
    chk("bp_wr_cnt", exp_wr, 8);
    chk("bp_done_once", done_cnt, 1);
`ifdef NPU_ACT_SEQ_PERF_EN
    chk("bp_perf_stall", perf_stall_o, 5);
`endif

    // Zero length
    start_job(0, 3, 8'h33);
    wait_done("zero", 20);
    chk("zero_done_lat", done_cyc - start_cyc, 1);
    chk("zero_no_reads", ren_cnt, 0);
    chk("zero_never_busy", busy_seen, 0);
    chk("zero_type_latched", act_type_o, 3);

    // Start while busy
    start_job(5, 2, 8'h44);
    repeat (2) step();
    start_i = 1'b1; len_i = 8'd2; type_i = 2'd1;
    step();
    start_i = 1'b0;
    wait_done("sw", 60);
    repeat (5) step();
    chk("sw_ren_cnt", ren_cnt, 5);
    chk("sw_wr_cnt", exp_wr, 5);
    chk("sw_one_done", done_cnt, 1);
    chk("sw_type_kept", act_type_o, 2);

    // Abort mid-run
    start_job(16, 0, 8'h55);
    wait_xfers("abort", 5, 40);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    #1;
    chk("abort_idle_next", busy_o, 0);
    repeat (4) step();
    chk("abort_no_done", done_cnt, 0);
    start_job(3, 1, 8'h66);
    wait_done("post_abort", 40);
    chk("post_abort_first_ren", first_ren_cyc - start_cyc, 1);
    chk("post_abort_ren_cnt", ren_cnt, 3);
    chk("post_abort_wr_cnt", exp_wr, 3);

    // Reset during drain
    start_job(8, 1, 8'h77);
    n = 0;
    while (ren_cnt < 8 && n < 40) begin
      step();
      n++;
    end
    chk("rst_reached_drain", ren_cnt, 8);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs_zero", outputs_zero(), 1);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("rst_release_outputs_zero", outputs_zero(), 1);
    chk("rst_no_done", done_cnt, 0);
`ifdef NPU_ACT_SEQ_PERF_EN
    chk("rst_perf_cycles", perf_cycles_o, 0);
`endif
    start_job(2, 3, 8'h88);
    wait_done("post_rst", 30);
    chk("post_rst_wr_cnt", exp_wr, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
